gc_table_streamer: RTL

- Downstream of the garbling engine: captures per-gate garbled-table pairs (t0, t1) tagged with gate id, buffers them in a FIFO and serialises them into W-bit words over a valid/ready stream toward the host/DMA link.
- The engine is free-running with no backpressure, so the block absorbs bursts; loss on overflow is flagged, never silent.
- XOR-class gates produce no table (free-XOR); the engine side marks table-bearing gates with in_table.

---
 rtl/gc_table_streamer.sv | 109 ++++++++++
 1 files changed

// File: rtl/gc_table_streamer.sv
// Garbled-table streamer: buffers (gid, t0, t1) entries from the garbling engine in a FIFO
// and serialises each entry as N W-bit words (t0 LSW first, then t1) on a valid/ready stream.
module gc_table_streamer #(
    parameter int S     = 20,
    parameter int K     = 128,
    parameter int W     = 32,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic          in_table,
    input  logic [S-1:0]  in_gid,
    input  logic [K-1:0]  t0,
    input  logic [K-1:0]  t1,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_data,
    output logic [S-1:0]  out_gid,
    output logic          out_last,
    output logic [AW:0]   level,
    output logic          overflow
);

    localparam int N  = 2 * K / W;
    localparam int NW = (N > 1) ? $clog2(N) : 1;
    localparam int E  = S + 2 * K;

    logic [E-1:0]   r_mem [DEPTH];
    logic [AW-1:0]  r_wptr;
    logic [AW-1:0]  r_rptr;
    logic [NW-1:0]  r_wcnt;
    logic [AW:0]    r_level;
    logic           r_overflow;

    logic           w_req;
    logic           w_full;
    logic           w_last_word;
    logic           w_xfer;
    logic           w_pop;
    logic           w_push;
    logic           w_drop;
    logic [E-1:0]   w_head;
    logic [2*K-1:0] w_rows;

    assign w_req       = in_valid & in_table;
    assign w_full      = (r_level == (AW+1)'(DEPTH));
    assign out_valid   = (r_level != '0);
    assign w_last_word = (r_wcnt == NW'(N - 1));
    assign w_xfer      = out_valid & out_ready;
    assign w_pop       = w_xfer & w_last_word;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts.
    assign w_push      = w_req & (~w_full | w_pop);
    assign w_drop      = w_req & w_full & ~w_pop;

    // Entry layout is {gid, t0, t1}; swap rows so word i is simply w_rows[W*i +: W].
    assign w_head   = r_mem[r_rptr];
    assign w_rows   = {w_head[K-1:0], w_head[2*K-1:K]};
    assign out_gid  = w_head[E-1:2*K];
    assign out_last = out_valid & w_last_word;
    assign level    = r_level;
    assign overflow = r_overflow;

    always_comb begin
        out_data = '0;
        for (int i = 0; i < N; i++) begin
            if (r_wcnt == NW'(i)) begin
                out_data = w_rows[W*i +: W];
            end
        end
    end

    // Storage is deliberately not reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= {in_gid, t0, t1};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_wcnt     <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            if (w_xfer) begin
                r_wcnt <= w_last_word ? '0 : r_wcnt + NW'(1);
            end
            if (w_push && !w_pop) begin
                r_level <= r_level + (AW+1)'(1);
            end else if (w_pop && !w_push) begin
                r_level <= r_level - (AW+1)'(1);
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

endmodule
